// File: rtl/sobel_pkg.sv
// sobel_pkg: shared gray coefficients, default frame size and pad FSM states.
package sobel_pkg;
  localparam int IMG_W_DEF = 480;
  localparam int IMG_H_DEF = 360;
  localparam int COEF_R = 1224;
  localparam int COEF_G = 2404;
  localparam int COEF_B = 466;
  localparam int GRAY_SHIFT = 12;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pad_state_t;
endpackage

// File: rtl/sobel_pad_streamer_rgb2gray.sv
// rgb2gray: fixed-point RGB to 8-bit gray; SOBEL_GRAY_ROUND_EN selects round-to-nearest over truncation.
module rgb2gray
  import sobel_pkg::*;
(
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic [7:0] gray_o
);
`ifdef SOBEL_GRAY_ROUND_EN
  localparam logic [19:0] RND = 20'(1 << (GRAY_SHIFT - 1));
`else
  localparam logic [19:0] RND = 20'd0;
`endif
  logic [19:0] sum;
  // Worst case stays below 2^20 even with rounding, so no saturation.
  assign sum = 20'(r_i) * 20'(COEF_R) + 20'(g_i) * 20'(COEF_G) + 20'(b_i) * 20'(COEF_B) + RND;
  assign gray_o = sum[GRAY_SHIFT +: 8];
endmodule

// File: rtl/sobel_pad_streamer.sv
// sobel_pad_streamer: converts raster RGB to gray and emits it with a one-pixel zero border.
// Optional round-to-nearest gray via SOBEL_GRAY_ROUND_EN (in rgb2gray).
module sobel_pad_streamer
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CNT_W = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_r,
  input  logic [7:0] in_g,
  input  logic [7:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       frame_done
);
  localparam logic [CNT_W-1:0] COL_END = CNT_W'(IMG_W + 1);
  localparam logic [CNT_W-1:0] ROW_END = CNT_W'(IMG_H + 1);
  pad_state_t state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic out_valid_q, out_valid_d;
  logic [7:0] out_data_q, out_data_d, gray;
  logic free, border, last, load;
  rgb2gray u_gray (
    .r_i(in_r),
    .g_i(in_g),
    .b_i(in_b),
    .gray_o(gray)
  );
  assign free = !out_valid_q || out_ready;
  assign border = row_q == '0 || row_q == ROW_END || col_q == '0 || col_q == COL_END;
  assign last = row_q == ROW_END && col_q == COL_END;
  assign in_ready = state_q == RUN && free && !border;
  // Border slots self-fill; interior slots wait for an input handshake.
  assign load = state_q == RUN && free && (border || in_valid);
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign busy = state_q == RUN || state_q == DRAIN;
  assign frame_done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        row_d = '0;
        col_d = '0;
      end
      RUN: if (load) begin
        out_valid_d = 1'b1;
        out_data_d = border ? 8'd0 : gray;
        col_d = col_q == COL_END ? '0 : col_q + 1'b1;
        row_d = col_q == COL_END ? row_q + 1'b1 : row_q;
        state_d = last ? DRAIN : RUN;
      end else if (free) out_valid_d = 1'b0;
      DRAIN: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
endmodule

// File: doc/sobel_pad_streamer.md
Name: sobel_pad_streamer

Overview:
- Hardware source side of the sobel pixel interface.
- Accepts raster-order RGB pixels from an upstream image source and converts each one to 8-bit gray.
- Surrounds the frame with a one-pixel zero border and emits one gray byte per accepted transfer to the sobel core.
- Output order matches what the sobel core consumes: (IMG_W+2) x (IMG_H+2) bytes, row-major, border bytes = 0.

Parameters:
- IMG_W, 480, interior image width in pixels.
- IMG_H, 360, interior image height in pixels.
- CNT_W, 9, width of the row and column counters; must hold IMG_W+1 and IMG_H+1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a frame; ignored unless in IDLE.
- in_valid  in  1  RGB pixel available.
- in_ready  out  1  pixel consumed this cycle when in_valid && in_ready.
- in_r  in  8  red.
- in_g  in  8  green.
- in_b  in  8  blue.
- out_valid  out  1  out_data holds a valid byte.
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready.
- out_data  out  8  padded gray byte to the sobel data input.
- busy  out  1  high from the cycle after an accepted start until the frame completes.
- frame_done  out  1  one-cycle pulse after the last byte transfers.

Behaviour:
- Reset values: out_valid=0, out_data=0, in_ready=0, busy=0, frame_done=0, state=IDLE, row=0, col=0.
- States:
  - IDLE: on start go to RUN, row=0, col=0.
  - RUN: produce bytes, advancing position on each slot load.
  - DONE: one cycle, frame_done=1, then back to IDLE.
- Output register:
  - The slot is free when !out_valid || out_ready.
  - A new byte loads only when the slot is free.
  - Latency from input acceptance to out_valid is one cycle.
  - out_data is held stable while out_valid && !out_ready.
- Border position: row==0, row==IMG_H+1, col==0 or col==IMG_W+1.
  - The slot loads 0 with out_valid=1.
  - No input is required.
  - in_ready=0.
- Interior position:
  - in_ready = slot free && state==RUN.
  - On handshake, load gray and set out_valid=1.
  - Without in_valid the slot is not loaded: out_valid falls once the previous byte drains.
  - Counters hold and no border byte is substituted.
- Gray conversion:
  - sum = in_r*1224 + in_g*2404 + in_b*466, 20-bit unsigned.
  - gray = sum[19:12].
  - Maximum sum is 1,043,970, so there is no overflow.
- Counter advance (on each slot load in RUN):
  - col increments; when col==IMG_W+1, col wraps to 0 and row increments.
  - Loading position (IMG_H+1, IMG_W+1) moves to a drain substate. It waits until the last byte transfers, then goes to DONE.
- Total bytes per frame: (IMG_W+2)*(IMG_H+2); 174,484 at the defaults.
- start while busy: ignored.
- rst mid-frame: takes effect at the next edge and restores all reset values. Any pending byte is discarded.
- in_valid in IDLE/DONE: in_ready=0 and the input is not consumed.

Optional Feature:
- Macro name: SOBEL_GRAY_ROUND_EN.
- Defined: gray = (sum + 2048)[19:12], i.e. round-to-nearest. The maximum is 1,046,018, still below 2^20, so no saturation logic is needed.
- Undefined: truncation as specified above. This is bit-exact with the software golden model.

Decomposition:
- Shared package sobel_pkg:
  - Coefficient constants COEF_R=1224, COEF_G=2404, COEF_B=466, GRAY_SHIFT=12.
  - Typedef pad_state_t {IDLE, RUN, DRAIN, DONE}.
  - Default IMG_W and IMG_H constants.
- One sub-module, rgb2gray: combinational multiply-add plus shift, including the SOBEL_GRAY_ROUND_EN option.
- Counters, FSM and output register stay in sobel_pad_streamer.

Test Plan (IMG_W=4, IMG_H=3, i.e. 6x5 = 30 bytes):
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, in_ready=0, busy=0, out_data=0 throughout.
- Normal frame: start, all pixels (255,255,255), out_ready=1.
  - First 7 bytes are 0, then 254,254,254,254, then 0,0, and so on.
  - Exactly 30 transfers and exactly 12 interior bytes = 254.
  - frame_done pulses once, one cycle after the 30th transfer.
  - With SOBEL_GRAY_ROUND_EN the interior bytes are 255.
- Arithmetic: pixels (100,0,0) -> 29; (0,0,255) -> 29; (0,100,0) -> 58.
- Input stall: drop in_valid for 5 cycles at interior position (2,3).
  - out_valid=0 during the gap, no extra zeros are inserted, the byte count stays 30, and the sequence is unchanged.
- Backpressure: hold out_ready=0 for 4 cycles.
  - out_data is stable, in_ready=0, and the border position does not advance.
- Mid-frame reset and start while busy:
  - A start pulse at byte 10 while busy is ignored.
  - rst at byte 15 -> IDLE next cycle.
  - A new start then produces a full 30-byte frame beginning with 0.
